mpd_prj_sel: RTL and testbench

Parametrised user-project selector and reset sequencer that sits between the eFPGA top-side user IO and N hardened user projects.
- Selects which project's output bus drives the fabric input bus, based on a fabric-driven select.
- Sequences a clean switch: blank the bus, hold the projects in reset, then release.
- Keeps every non-active project in reset.
- Provides a parametrised heartbeat so the clock can be confirmed alive.

---
 rtl/mpd_prj_sel_if.sv | 29 ++
 rtl/mpd_prj_sel.sv | 166 ++++++++++++++++
 tb/tb_mpd_prj_sel.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mpd_prj_sel_if.sv
// mpd_prj_sel_if: fabric/project side bus of the project selector.
// master = fabric/project side, slave = selector.
interface mpd_prj_sel_if #(
  parameter int NUM_PRJ = 4,
  parameter int SEL_W   = 2,
  parameter int OUT_W   = 128
);
  logic [SEL_W-1:0]         sel_i;
  logic                     usr_reset_i;
  logic [NUM_PRJ*OUT_W-1:0] prj_out_i;
  logic [OUT_W-1:0]         fab_uin_o;
  logic [NUM_PRJ-1:0]       prj_reset_o;
  logic [SEL_W-1:0]         active_o;
  logic                     switching_o;
  logic                     sel_err_o;
  logic                     heart_o;

  modport master (
    output sel_i, usr_reset_i, prj_out_i,
    input  fab_uin_o, prj_reset_o, active_o,
    input  switching_o, sel_err_o, heart_o
  );

  modport slave (
    input  sel_i, usr_reset_i, prj_out_i,
    output fab_uin_o, prj_reset_o, active_o,
    output switching_o, sel_err_o, heart_o
  );
endinterface

// File: rtl/mpd_prj_sel.sv
// mpd_prj_sel: user-project selector + reset sequencer with heartbeat.
// Optional MPD_PRJ_OUT_REG_EN registers fab_uin_o (one clock lag).
module mpd_prj_sel #(
  parameter int NUM_PRJ       = 4,
  parameter int SEL_W         = 2,
  parameter int OUT_W         = 128,
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int HEART_W       = 22
) (
  input  logic        clk,
  input  logic        reset,
  mpd_prj_sel_if.slave bus
);

  localparam int HW  = $clog2(RST_CYCLES);
  localparam int STW = (STABLE_CYCLES > 1) ?
                       $clog2(STABLE_CYCLES) : 1;
  localparam logic [HW-1:0]  RST_LD   = HW'(RST_CYCLES - 1);
  localparam logic [STW-1:0] STAB_MAX = STW'(STABLE_CYCLES - 1);
  localparam logic [SEL_W:0] NUM_L    = (SEL_W+1)'(NUM_PRJ);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    PARK
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   s1_q, s1_d;
  logic [SEL_W-1:0]   sel_s_q, sel_s_d;
  logic [STW-1:0]     stab_q, stab_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic [HW-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]   act_q, act_d;
  logic [HEART_W-1:0] heart_q, heart_d;
  logic [OUT_W-1:0]   mux;
  logic [NUM_PRJ-1:0] rst_vec;
  logic               sel_ok;
  logic               run;

  assign sel_ok = {1'b0, sel_q} < NUM_L;
  assign run    = (state_q == RUN);

  // synchronise sel_i and accept it once it has been stable long enough
  always_comb begin
    s1_d    = bus.sel_i;
    sel_s_d = s1_q;
    stab_d  = stab_q;
    sel_d   = sel_q;
    if (s1_q != sel_s_q) begin
      stab_d = '0;
    end else if (stab_q == STAB_MAX) begin
      sel_d = sel_s_q;
    end else begin
      stab_d = stab_q + 1'b1;
    end
  end

  // switch sequencing: blank + hold in reset, then run the target
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    unique case (state_q)
      HOLD: begin
        if (sel_ok && sel_q != tgt_q) begin
          tgt_d = sel_q;
          cnt_d = RST_LD;
        end else if (cnt_q == '0) begin
          state_d = RUN;
          act_d   = tgt_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RUN: begin
        if (!sel_ok) begin
          state_d = PARK;
        end else if (sel_q != act_q) begin
          state_d = HOLD;
          tgt_d   = sel_q;
          cnt_d   = RST_LD;
        end
      end
      PARK: begin
        if (sel_ok) begin
          state_d = HOLD;
          tgt_d   = sel_q;
          cnt_d   = RST_LD;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // heartbeat free-runs and wraps
  always_comb begin
    heart_d = heart_q + 1'b1;
  end

  // output mux and per-project reset vector
  always_comb begin
    mux     = '0;
    rst_vec = '1;
    for (int k = 0; k < NUM_PRJ; k++) begin
      if (act_q == SEL_W'(k)) begin
        mux = bus.prj_out_i[k*OUT_W +: OUT_W];
        if (run) rst_vec[k] = bus.usr_reset_i;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      sel_s_q <= '0;
      stab_q  <= '0;
      sel_q   <= '0;
      state_q <= HOLD;
      tgt_q   <= '0;
      cnt_q   <= RST_LD;
      act_q   <= '0;
      heart_q <= '0;
    end else begin
      s1_q    <= s1_d;
      sel_s_q <= sel_s_d;
      stab_q  <= stab_d;
      sel_q   <= sel_d;
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      heart_q <= heart_d;
    end
  end

`ifdef MPD_PRJ_OUT_REG_EN
  logic [OUT_W-1:0] fab_q, fab_d;

  // registered bus: blanked one clock after leaving RUN
  always_comb begin
    fab_d = run ? mux : '0;
  end

  // output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fab_q <= '0;
    else       fab_q <= fab_d;
  end

  assign bus.fab_uin_o = fab_q;
`else
  assign bus.fab_uin_o = run ? mux : '0;
`endif

  assign bus.prj_reset_o = rst_vec;
  assign bus.active_o    = act_q;
  assign bus.switching_o = !run;
  assign bus.sel_err_o   = (state_q == PARK) || !sel_ok;
  assign bus.heart_o     = heart_q[HEART_W-1];

endmodule

// File: tb/tb_mpd_prj_sel.sv
// tb_mpd_prj_sel: directed bench with a cycle model for mpd_prj_sel.
// Three slots so that select 3 exercises the parked path.
module tb_mpd_prj_sel;

  localparam int NP  = 3;
  localparam int SW  = 2;
  localparam int OW  = 32;
  localparam int RST = 16;
  localparam int STB = 4;
  localparam int HWD = 4;

  localparam int M_HOLD = 0;
  localparam int M_RUN  = 1;
  localparam int M_PARK = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mpd_prj_sel_if #(.NUM_PRJ(NP), .SEL_W(SW), .OUT_W(OW)) bus ();

  mpd_prj_sel #(
    .NUM_PRJ(NP), .SEL_W(SW), .OUT_W(OW),
    .RST_CYCLES(RST), .STABLE_CYCLES(STB), .HEART_W(HWD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] pat [NP] = '{32'hA5A5A5A5, 32'h3C3C3C3C, 32'h0F0F0F0F};

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // ---------------- model ----------------
  int smp [0:STB];
  int acc, mode, left, tgt, act, hc;
  logic [31:0] fab_reg;

  function automatic logic [31:0] m_fab_comb();
    return (mode == M_RUN) ? pat[act] : 32'h0;
  endfunction

  function automatic logic [31:0] m_fab();
`ifdef MPD_PRJ_OUT_REG_EN
    return fab_reg;
`else
    return m_fab_comb();
`endif
  endfunction

  function automatic int m_rst();
    int r;
    r = (1 << NP) - 1;
    if (mode == M_RUN && !bus.usr_reset_i) r = r & ~(1 << act);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    int a_old;
    int same;
    if (reset) begin
      for (int j = 0; j <= STB; j++) smp[j] = 0;
      acc = 0; mode = M_HOLD; left = RST;
      tgt = 0; act = 0; hc = 0; fab_reg = '0;
    end else begin
      fab_reg = m_fab_comb();
      a_old = acc;
      same = 1;
      for (int j = 2; j <= STB; j++)
        if (smp[j] != smp[1]) same = 0;
      if (same != 0) acc = smp[1];
      for (int j = STB; j >= 1; j--) smp[j] = smp[j-1];
      smp[0] = int'(bus.sel_i);
      case (mode)
        M_HOLD: begin
          if (a_old < NP && a_old != tgt) begin
            tgt = a_old; left = RST;
          end else begin
            left = left - 1;
            if (left == 0) begin mode = M_RUN; act = tgt; end
          end
        end
        M_RUN: begin
          if (a_old >= NP) mode = M_PARK;
          else if (a_old != act) begin
            mode = M_HOLD; tgt = a_old; left = RST;
          end
        end
        default: begin
          if (a_old < NP) begin
            mode = M_HOLD; tgt = a_old; left = RST;
          end
        end
      endcase
      hc = (hc + 1) % (1 << HWD);
    end
  end

  // every-cycle compare against the model
  always @(posedge clk) begin
    #1;
    chk("fab", 64'(bus.fab_uin_o), 64'(m_fab()));
    chk("prj_rst", 64'(bus.prj_reset_o), 64'(m_rst()));
    chk("active", 64'(bus.active_o), 64'(act));
    chk("switching", 64'(bus.switching_o), 64'(mode != M_RUN));
    chk("sel_err", 64'(bus.sel_err_o),
        64'(mode == M_PARK || acc >= NP));
    chk("heart", 64'(bus.heart_o), 64'(hc >= (1 << (HWD-1))));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.sel_i       = '0;
    bus.usr_reset_i = 1'b0;
    bus.prj_out_i   = {pat[2], pat[1], pat[0]};

    // power-on
    cyc(3);
    chk("por_rst", 64'(bus.prj_reset_o), 64'h7);
    chk("por_fab", 64'(bus.fab_uin_o), 64'h0);
    chk("por_act", 64'(bus.active_o), 64'h0);
    chk("por_sw", 64'(bus.switching_o), 64'h1);
    chk("por_err", 64'(bus.sel_err_o), 64'h0);
    reset = 1'b0;
    cyc(15);
    chk("po_hold_rst", 64'(bus.prj_reset_o), 64'h7);
    chk("po_hold_sw", 64'(bus.switching_o), 64'h1);
    chk("po_heart15", 64'(bus.heart_o), 64'h1);
    cyc(1);
    chk("po_run_rst", 64'(bus.prj_reset_o), 64'h6);
    chk("po_run_sw", 64'(bus.switching_o), 64'h0);
    chk("po_heart16", 64'(bus.heart_o), 64'h0);
    cyc(1);
    chk("po_run_fab", 64'(bus.fab_uin_o), 64'hA5A5A5A5);

    // switch 0 -> 2
    bus.sel_i = 2'd2;
    cyc(6);
    chk("sw_pre_sw", 64'(bus.switching_o), 64'h0);
    chk("sw_pre_act", 64'(bus.active_o), 64'h0);
    cyc(1);
    chk("sw_hold_sw", 64'(bus.switching_o), 64'h1);
    chk("sw_hold_rst", 64'(bus.prj_reset_o), 64'h7);
    cyc(15);
    chk("sw_end_sw", 64'(bus.switching_o), 64'h1);
    chk("sw_end_fab", 64'(bus.fab_uin_o), 64'h0);
    cyc(1);
    chk("sw_run_act", 64'(bus.active_o), 64'h2);
    chk("sw_run_rst", 64'(bus.prj_reset_o), 64'h3);
    chk("sw_run_sw", 64'(bus.switching_o), 64'h0);
    cyc(1);
    chk("sw_run_fab", 64'(bus.fab_uin_o), 64'h0F0F0F0F);

    // glitch shorter than the stability window
    bus.sel_i = 2'd0;
    cyc(2);
    bus.sel_i = 2'd2;
    cyc(10);
    chk("gl_act", 64'(bus.active_o), 64'h2);
    chk("gl_sw", 64'(bus.switching_o), 64'h0);

    // out-of-range select parks
    bus.sel_i = 2'd3;
    cyc(6);
    chk("pk_err_early", 64'(bus.sel_err_o), 64'h1);
    cyc(1);
    chk("pk_sw", 64'(bus.switching_o), 64'h1);
    chk("pk_rst", 64'(bus.prj_reset_o), 64'h7);
    chk("pk_act", 64'(bus.active_o), 64'h2);
    cyc(10);
    chk("pk_fab", 64'(bus.fab_uin_o), 64'h0);
    chk("pk_err", 64'(bus.sel_err_o), 64'h1);
    bus.sel_i = 2'd1;
    cyc(7);
    chk("unpk_err", 64'(bus.sel_err_o), 64'h0);
    chk("unpk_sw", 64'(bus.switching_o), 64'h1);
    cyc(16);
    chk("unpk_act", 64'(bus.active_o), 64'h1);
    chk("unpk_rst", 64'(bus.prj_reset_o), 64'h5);
    cyc(1);
    chk("unpk_fab", 64'(bus.fab_uin_o), 64'h3C3C3C3C);

    // user reset pulse on the active project
    bus.usr_reset_i = 1'b1;
    cyc(1);
    chk("ur_rst1", 64'(bus.prj_reset_o), 64'h7);
    chk("ur_sw", 64'(bus.switching_o), 64'h0);
    cyc(4);
    chk("ur_rst5", 64'(bus.prj_reset_o), 64'h7);
    chk("ur_act", 64'(bus.active_o), 64'h1);
    bus.usr_reset_i = 1'b0;
    cyc(1);
    chk("ur_rel", 64'(bus.prj_reset_o), 64'h5);

    // reset in the middle of a hold
    bus.sel_i = 2'd0;
    cyc(7);
    chk("mh_sw", 64'(bus.switching_o), 64'h1);
    cyc(8);
    reset = 1'b1;
    #1;
    chk("mh_rst", 64'(bus.prj_reset_o), 64'h7);
    chk("mh_act", 64'(bus.active_o), 64'h0);
    chk("mh_heart", 64'(bus.heart_o), 64'h0);
    cyc(2);
    reset = 1'b0;
    cyc(15);
    chk("mh_hold_sw", 64'(bus.switching_o), 64'h1);
    chk("mh_heart15", 64'(bus.heart_o), 64'h1);
    cyc(1);
    chk("mh_run_sw", 64'(bus.switching_o), 64'h0);
    chk("mh_run_rst", 64'(bus.prj_reset_o), 64'h6);
    chk("mh_heart16", 64'(bus.heart_o), 64'h0);
    cyc(1);
    chk("mh_run_fab", 64'(bus.fab_uin_o), 64'hA5A5A5A5);

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
